multicycle_controller: RTL and testbench

//  Control FSM for a multi-cycle build of the MIPS-subset core (ADD/AND/OR/SLT/SLL/SRL/SUB/JR, ADDI,
//  BEQ, BNE, LW, SW, JAL). It sits beside the shared ALU, register file and unified memory and

---
 rtl/multicycle_controller_if.sv | 10 +
 rtl/multicycle_controller.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Memory-side handshake between the multi-cycle controller and the unified memory.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic IorD;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output IorD, input mem_ready);
    modport slave  (input mem_req, input mem_we, input IorD, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS-subset core: sequences ALU, register file and
// memory one step per state, with a memory watchdog and a sticky trap.
//
// state  | meaning
// IDLE   | one cycle after reset, no activity
// FETCH  | read instruction at PC, PC+4 into PC when memory answers
// DECODE | dispatch on opcode, precompute branch target
// MEMADR | effective address for LW/SW
// MEMRD  | data read at ALUOut
// MEMWB  | load data written to rt
// MEMWR  | data write at ALUOut, retires on ready
// REXEC  | R-type ALU operation
// ALUWB  | R-type result written to rd
// BRANCH | BEQ/BNE compare and conditional PC load
// ADDIEX | ADDI add
// ADDIWB | ADDI result written to rt
// JALS   | jump and link to r31
// JR     | jump to rs
// TRAP   | illegal opcode or memory timeout, left only by reset
module multicycle_controller #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [5:0]                     Opcode,
    input  logic [5:0]                     Funct,
    input  logic                           Zero,
    multicycle_controller_if.master        mem,
    output logic                           IRWrite,
    output logic                           PCWrite,
    output logic [1:0]                     PCSrc,
    output logic                           ALUSrcA,
    output logic [1:0]                     ALUSrcB,
    output logic [1:0]                     ALUOp,
    output logic                           RegWrite,
    output logic                           RegDest,
    output logic                           MemToReg,
    output logic                           JAL,
    output logic                           retire,
    output logic                           err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam int            CW         = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_WAIT_MAX);
    localparam logic [CW-1:0] CNT_SAT    = '1;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        REXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JALS, JR, TRAP
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          req;
    logic          waiting;
    logic          wd_expire;

    assign waiting   = req && !mem.mem_ready;
    assign wd_expire = waiting && (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            // Counts only stalled request cycles; any ready or non-memory cycle clears it.
            if (waiting) begin
                if (wait_cnt != CNT_SAT) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                IDLE:   state <= FETCH;
                FETCH: begin
                    if (wd_expire)          state <= TRAP;
                    else if (mem.mem_ready) state <= DECODE;
                end
                DECODE: begin
                    case (Opcode)
                        OP_RTYPE:       state <= (Funct == FN_JR) ? JR : REXEC;
                        OP_LW, OP_SW:   state <= MEMADR;
                        OP_BEQ, OP_BNE: state <= BRANCH;
                        OP_ADDI:        state <= ADDIEX;
                        OP_JAL:         state <= JALS;
                        default:        state <= TRAP;
                    endcase
                end
                MEMADR: state <= (Opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD: begin
                    if (wd_expire)          state <= TRAP;
                    else if (mem.mem_ready) state <= MEMWB;
                end
                MEMWR: begin
                    if (wd_expire)          state <= TRAP;
                    else if (mem.mem_ready) state <= FETCH;
                end
                REXEC:  state <= ALUWB;
                ADDIEX: state <= ADDIWB;
                MEMWB, ALUWB, BRANCH, ADDIWB, JALS, JR: state <= FETCH;
                TRAP:   state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end

    always_comb begin
        req      = 1'b0;
        mem.mem_we = 1'b0;
        mem.IorD = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        RegWrite = 1'b0;
        RegDest  = 1'b0;
        MemToReg = 1'b0;
        JAL      = 1'b0;
        retire   = 1'b0;
        err      = 1'b0;
        case (state)
            FETCH: begin
                req     = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem.mem_ready;
                PCWrite = mem.mem_ready;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                req      = 1'b1;
                mem.IorD = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                req        = 1'b1;
                mem.mem_we = 1'b1;
                mem.IorD   = 1'b1;
                retire     = mem.mem_ready;
            end
            REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDest  = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                PCWrite = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);
                retire  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            JALS: begin
                PCSrc    = 2'b10;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                JAL      = 1'b1;
                retire   = 1'b1;
            end
            JR: begin
                PCSrc   = 2'b11;
                PCWrite = 1'b1;
                retire  = 1'b1;
            end
            TRAP:    err = 1'b1;
            default: ;
        endcase
        mem.mem_req = req;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction vector table with a retire
// scoreboard, plus hand sequences for trap, watchdog and reset-during-wait.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       IRWrite, PCWrite, ALUSrcA, RegWrite, RegDest, MemToReg, JAL, retire, err;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic [17:0] outs;

    multicycle_controller_if mif();

    multicycle_controller #(.MEM_WAIT_MAX(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Opcode   (Opcode),
        .Funct    (Funct),
        .Zero     (Zero),
        .mem      (mif),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .PCSrc    (PCSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .RegWrite (RegWrite),
        .RegDest  (RegDest),
        .MemToReg (MemToReg),
        .JAL      (JAL),
        .retire   (retire),
        .err      (err)
    );

    assign outs = {mif.mem_req, mif.mem_we, mif.IorD, IRWrite, PCWrite, PCSrc, ALUSrcA,
                   ALUSrcB, ALUOp, RegWrite, RegDest, MemToReg, JAL, retire, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        int         fw;
        int         dw;
        int         lat;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       regw;
        logic       regdest;
        logic       m2r;
        logic       jal;
        logic       we;
        logic [4:0] ex;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Leaves the DUT in its first FETCH cycle, at posedge+1.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        mif.mem_ready = 1'b0;
        #2;
        chk("reset_outs", 32'(outs), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        chk("idle_outs", 32'(outs), 32'h0);
        @(posedge clk); #1;
        chk("fetch_after_reset", {30'h0, mif.mem_req, mif.IorD}, 32'h2);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int   fw_left = v.fw;
        int   dw_left = v.dw;
        int   irw = 0, pcw = 0, regw = 0;
        bit   done = 1'b0;
        Opcode = v.op;
        Funct  = v.fn;
        Zero   = v.zero;
        sb.push_back(v);
        for (int c = 1; c <= 40 && !done; c++) begin
            if (mif.mem_req) begin
                if (!mif.IorD) begin
                    mif.mem_ready = (fw_left == 0);
                    if (fw_left > 0) fw_left--;
                end else begin
                    mif.mem_ready = (dw_left == 0);
                    if (dw_left > 0) dw_left--;
                end
            end else begin
                mif.mem_ready = 1'b1;  // must be ignored outside memory states
            end
            #2;
            if (c == 1)
                chk($sformatf("v%0d_fetch", idx), {30'h0, mif.mem_req, mif.IorD}, 32'h2);
            if (c == v.fw + 2)
                chk($sformatf("v%0d_decode", idx),
                    {26'h0, mif.mem_req, ALUSrcA, ALUSrcB, ALUOp}, 32'b0_0_11_00);
            if (c == v.fw + 3)
                chk($sformatf("v%0d_exec", idx), {27'h0, ALUSrcA, ALUSrcB, ALUOp}, 32'(v.ex));
            if (err) chk($sformatf("v%0d_err", idx), 32'(err), 32'h0);
            irw  += int'(IRWrite);
            pcw  += int'(PCWrite);
            regw += int'(RegWrite);
            if (retire) begin
                done = 1'b1;
                chk($sformatf("v%0d_sb_depth", idx), 32'(sb.size()), 32'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_latency", idx), 32'(c), 32'(e.lat));
                    chk($sformatf("v%0d_retire_outs", idx),
                        {22'h0, PCWrite, PCSrc, RegWrite, RegDest, MemToReg, JAL, mif.mem_we,
                         mif.mem_req, mif.IorD},
                        {22'h0, e.pcw, e.pcsrc, e.regw, e.regdest, e.m2r, e.jal, e.we,
                         e.we, e.we});
                end
            end
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_retired", idx), 32'(done), 32'h1);
        chk($sformatf("v%0d_irwrite_cnt", idx), 32'(irw), 32'h1);
        chk($sformatf("v%0d_pcwrite_cnt", idx), 32'(pcw), 32'(1 + int'(v.pcw)));
        chk($sformatf("v%0d_regwrite_cnt", idx), 32'(regw), 32'(v.regw));
    endtask

    initial begin
        int trap_at;
        rst_n = 1'b0;
        Opcode = 6'h0;
        Funct = 6'h0;
        Zero = 1'b0;
        mif.mem_ready = 1'b0;

        //            op         fn         z   fw dw lat pcw  pcsrc  rw   rd   m2r  jal  we   ex
        vecs[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10010};
        vecs[1]  = '{6'b000000, 6'b100010, 1'b1, 2, 0, 6, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10010};
        vecs[2]  = '{6'b100011, 6'b000000, 1'b0, 0, 0, 5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000};
        vecs[3]  = '{6'b100011, 6'b000000, 1'b0, 0, 2, 7, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000};
        vecs[4]  = '{6'b101011, 6'b000000, 1'b0, 0, 0, 4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11000};
        vecs[5]  = '{6'b101011, 6'b000000, 1'b0, 3, 3, 10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11000};
        vecs[6]  = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10001};
        vecs[7]  = '{6'b000100, 6'b000000, 1'b0, 0, 0, 3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10001};
        vecs[8]  = '{6'b000101, 6'b000000, 1'b1, 0, 0, 3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10001};
        vecs[9]  = '{6'b000101, 6'b000000, 1'b0, 1, 0, 4, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10001};
        vecs[10] = '{6'b001000, 6'b000000, 1'b0, 0, 0, 4, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[11] = '{6'b000011, 6'b000000, 1'b0, 0, 0, 3, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000};
        vecs[12] = '{6'b000000, 6'b001000, 1'b0, 0, 0, 3, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};

        do_reset();
        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // LW abandoned by reset while its data read is stalled.
        Opcode = 6'b100011;
        Funct = 6'h0;
        mif.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mif.mem_ready = 1'b0;
        #2;
        chk("lw_memrd_req", {30'h0, mif.mem_req, mif.IorD}, 32'h3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("midwait_reset_outs", 32'(outs), 32'h0);
        do_reset();

        // Illegal opcode: sticky trap with every other output quiet.
        Opcode = 6'b111111;
        mif.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("trap_hold_%0d", i), 32'(outs), 32'h1);
            @(posedge clk); #3;
        end
        do_reset();
        chk("trap_cleared_err", 32'(err), 32'h0);

        // Watchdog with limit 3: four stalled fetch cycles, trap on the fifth.
        mif.mem_ready = 1'b0;
        trap_at = 0;
        for (int c = 1; c <= 10 && trap_at == 0; c++) begin
            #2;
            if (err) trap_at = c;
            else chk($sformatf("wd_req_%0d", c), 32'(mif.mem_req), 32'h1);
            @(posedge clk); #1;
        end
        chk("wd_trap_cycle", 32'(trap_at), 32'h5);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
